// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console front end.
package text_console_pkg;

  localparam int unsigned COLS_DEF = 80;
  localparam int unsigned ROWS_DEF = 60;
  localparam int unsigned CELLS    = COLS_DEF * ROWS_DEF;

  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_BS      = 8'h08;
  localparam logic [7:0] CH_FF      = 8'h0C;
  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] ATTR_RESET = 8'h07;

  typedef enum logic [2:0] {
    StIdle,
    StPutC,
    StPutA,
    StScrRd,
    StScrLat,
    StScrWr,
    StFill,
    StClr
  } state_e;

  function automatic logic [3:0] lane_sel(logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte-addressed bus between the console and the video block's RAM slave port.
interface text_console_if;
  logic [13:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        ack;

  modport master (
    output adr, dat_w, sel, we, stb,
    input  ack, dat_r
  );

  modport slave (
    input  adr, dat_w, sel, we, stb,
    output ack, dat_r
  );
endinterface

// File: rtl/tc_addr_gen.sv
// Cell address generator: cursor or linear cell index, plane offset, byte lane and lane select.
module tc_addr_gen
  import text_console_pkg::*;
#(
  parameter logic [13:0] COLOR_BASE = 14'h2000
) (
  input  logic [5:0]  row_i,
  input  logic [6:0]  col_i,
  input  logic [12:0] lin_idx_i,
  input  logic        use_lin_i,
  input  logic        plane_i,
  output logic [13:0] adr_o,
  output logic [1:0]  lane_o,
  output logic [3:0]  sel_o
);

  logic [12:0] cur_idx;
  logic [12:0] idx;

  // row*80 as row*64 + row*16
  assign cur_idx = 13'({row_i, 6'b0}) + 13'({row_i, 4'b0}) + 13'(col_i);
  assign idx     = use_lin_i ? lin_idx_i : cur_idx;
  assign adr_o   = (plane_i ? COLOR_BASE : 14'd0) + {1'b0, idx};
  assign lane_o  = adr_o[1:0];
  assign sel_o   = lane_sel(lane_o);

endmodule

// File: rtl/text_console.sv
// Character-stream front end: cursor handling, glyph/attribute writes, clear and scroll-up.
module text_console
  import text_console_pkg::*;
#(
  parameter int unsigned COLS           = COLS_DEF,
  parameter int unsigned ROWS           = ROWS_DEF,
  parameter logic [13:0] COLOR_BASE     = 14'h2000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk_25mhz,
  input  logic               rst_i,
  input  logic [7:0]         ch_dat_i,
  input  logic [7:0]         attr_i,
  input  logic               ch_valid_i,
  output logic               ch_ready_o,
  text_console_if.master     bus,
  output logic [6:0]         cur_col_o,
  output logic [5:0]         cur_row_o,
  output logic               busy_o
);

  localparam logic [6:0]  LastCol     = 7'(COLS - 1);
  localparam logic [5:0]  LastRow     = 6'(ROWS - 1);
  localparam logic [12:0] LastCell    = 13'(COLS * ROWS - 1);
  localparam logic [12:0] RowCells    = 13'(COLS);
  localparam logic [12:0] LastRowBase = 13'(COLS * ROWS - COLS);

  state_e      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [12:0] idx_q, idx_d;
  logic        plane_q, plane_d;
  logic [7:0]  ch_q, ch_d;
  logic [7:0]  attr_q, attr_d;
  logic [7:0]  rd_q, rd_d;
  // First cycle out of reset decides between the power-on clear and plain idle
  logic        boot_q;

  logic        stb, we, use_lin, plane_sel;
  logic [12:0] lin_idx;
  logic [31:0] dat_w;
  logic [13:0] gen_adr;
  logic [1:0]  gen_lane;
  logic [3:0]  gen_sel;
  logic        acc, take;

  tc_addr_gen #(
    .COLOR_BASE (COLOR_BASE)
  ) u_addr_gen (
    .row_i     (row_q),
    .col_i     (col_q),
    .lin_idx_i (lin_idx),
    .use_lin_i (use_lin),
    .plane_i   (plane_sel),
    .adr_o     (gen_adr),
    .lane_o    (gen_lane),
    .sel_o     (gen_sel)
  );

  assign acc  = stb & bus.ack;
  assign take = ch_valid_i & ch_ready_o;

  always_ff @(posedge clk_25mhz) begin
    if (!rst_i) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      plane_q <= 1'b0;
      ch_q    <= '0;
      attr_q  <= ATTR_RESET;
      rd_q    <= '0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      plane_q <= plane_d;
      ch_q    <= ch_d;
      attr_q  <= attr_d;
      rd_q    <= rd_d;
      boot_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    plane_d = plane_q;
    ch_d    = ch_q;
    attr_d  = attr_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle: begin
        if (boot_q) begin
          if (CLEAR_ON_RESET) begin
            state_d = StClr;
            idx_d   = '0;
            plane_d = 1'b0;
          end
        end else if (take) begin
          ch_d   = ch_dat_i;
          attr_d = attr_i;
          if (ch_dat_i == CH_CR) begin
            col_d = '0;
          end else if (ch_dat_i == CH_LF) begin
            col_d = '0;
            if (row_q != LastRow) begin
              row_d = row_q + 6'd1;
            end else begin
              state_d = StScrRd;
              idx_d   = RowCells;
              plane_d = 1'b0;
            end
          end else if (ch_dat_i == CH_BS) begin
            if (col_q != 7'd0) col_d = col_q - 7'd1;
          end else if (ch_dat_i == CH_FF) begin
            state_d = StClr;
            idx_d   = '0;
            plane_d = 1'b0;
            col_d   = '0;
            row_d   = '0;
          end else if (ch_dat_i >= CH_SPACE) begin
            state_d = StPutC;
          end
        end
      end
      StPutC: if (acc) state_d = StPutA;
      StPutA: begin
        if (acc) begin
          if (col_q == LastCol) begin
            col_d = '0;
            if (row_q != LastRow) begin
              row_d   = row_q + 6'd1;
              state_d = StIdle;
            end else begin
              state_d = StScrRd;
              idx_d   = RowCells;
              plane_d = 1'b0;
            end
          end else begin
            col_d   = col_q + 7'd1;
            state_d = StIdle;
          end
        end
      end
      StScrRd: if (acc) state_d = StScrLat;
      StScrLat: begin
        rd_d    = bus.dat_r[{gen_lane, 3'b000} +: 8];
        state_d = StScrWr;
      end
      StScrWr: begin
        if (acc) begin
          if (idx_q != LastCell) begin
            idx_d   = idx_q + 13'd1;
            state_d = StScrRd;
          end else if (!plane_q) begin
            plane_d = 1'b1;
            idx_d   = RowCells;
            state_d = StScrRd;
          end else begin
            plane_d = 1'b0;
            idx_d   = LastRowBase;
            state_d = StFill;
          end
        end
      end
      StFill, StClr: begin
        if (acc) begin
          if (idx_q != LastCell) begin
            idx_d = idx_q + 13'd1;
          end else if (!plane_q) begin
            plane_d = 1'b1;
            idx_d   = (state_q == StFill) ? LastRowBase : 13'd0;
          end else begin
            plane_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stb       = 1'b0;
    we        = 1'b0;
    dat_w     = '0;
    use_lin   = 1'b1;
    lin_idx   = idx_q;
    plane_sel = plane_q;
    unique case (state_q)
      StIdle: begin
        lin_idx   = '0;
        plane_sel = 1'b0;
      end
      StPutC: begin
        stb       = 1'b1;
        we        = 1'b1;
        use_lin   = 1'b0;
        plane_sel = 1'b0;
        dat_w     = {4{ch_q}};
      end
      StPutA: begin
        stb       = 1'b1;
        we        = 1'b1;
        use_lin   = 1'b0;
        plane_sel = 1'b1;
        dat_w     = {4{attr_q}};
      end
      StScrRd:  stb = 1'b1;
      // Address stays on the read cell so the lane mux picks the right byte
      StScrLat: stb = 1'b0;
      StScrWr: begin
        stb     = 1'b1;
        we      = 1'b1;
        lin_idx = idx_q - RowCells;
        dat_w   = {4{rd_q}};
      end
      StFill, StClr: begin
        stb   = 1'b1;
        we    = 1'b1;
        dat_w = plane_q ? {4{attr_q}} : {4{CH_SPACE}};
      end
      default: stb = 1'b0;
    endcase
  end

  assign bus.stb   = stb;
  assign bus.we    = we;
  assign bus.dat_w = dat_w;
  assign bus.adr   = gen_adr;
  assign bus.sel   = (state_q == StIdle) ? 4'b0000 : gen_sel;

  assign ch_ready_o = (state_q == StIdle) & ~boot_q;
  assign busy_o     = (state_q != StIdle) | (boot_q & CLEAR_ON_RESET);
  assign cur_col_o  = col_q;
  assign cur_row_o  = row_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console with a byte-addressed RAM slave model and optional wait states.
module tb_text_console;

  logic       clk_25mhz = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] ch_dat_i = '0;
  logic [7:0] attr_i = '0;
  logic       ch_valid_i = 1'b0;
  logic       ch_ready_o;
  logic       busy_o;
  logic [6:0] cur_col_o;
  logic [5:0] cur_row_o;

  text_console_if bus ();

  text_console #(
    .COLS           (80),
    .ROWS           (60),
    .COLOR_BASE     (14'h2000),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .rst_i      (rst_i),
    .ch_dat_i   (ch_dat_i),
    .attr_i     (attr_i),
    .ch_valid_i (ch_valid_i),
    .ch_ready_o (ch_ready_o),
    .bus        (bus.master),
    .cur_col_o  (cur_col_o),
    .cur_row_o  (cur_row_o),
    .busy_o     (busy_o)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:16383];
  int unsigned waits = 0;
  int unsigned wcnt  = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [13:0] log_adr [$];
  logic [31:0] log_dat [$];
  logic [3:0]  log_sel [$];
  logic        hold_prev = 1'b0;
  logic [13:0] h_adr;
  logic [31:0] h_dat;
  logic [3:0]  h_sel;
  logic        h_we;

  assign bus.ack = bus.stb && (wcnt == waits);

  always @(posedge clk_25mhz) wcnt <= (bus.stb && !bus.ack) ? wcnt + 1 : 0;

  // Slave model: acts on the completing cycle, read data presented for the following cycle
  always @(negedge clk_25mhz) begin
    if (bus.stb) begin
      if (hold_prev) begin
        n_assert++;
        assert (bus.adr === h_adr && bus.dat_w === h_dat && bus.sel === h_sel && bus.we === h_we)
        else begin
          n_fail++;
          $error("FAIL hold_stable: adr=%h dat=%h sel=%b we=%b required adr=%h dat=%h sel=%b we=%b",
                 bus.adr, bus.dat_w, bus.sel, bus.we, h_adr, h_dat, h_sel, h_we);
        end
      end
      hold_prev = !bus.ack;
      h_adr = bus.adr;
      h_dat = bus.dat_w;
      h_sel = bus.sel;
      h_we  = bus.we;
      if (bus.ack) begin
        n_assert++;
        assert (bus.sel === (4'b0001 << bus.adr[1:0]))
        else begin
          n_fail++;
          $error("FAIL bus_sel: observed %b for adr %h", bus.sel, bus.adr);
        end
        if (bus.we) begin
          mem[bus.adr] = bus.dat_w[8*bus.adr[1:0] +: 8];
          wr_cnt++;
          log_adr.push_back(bus.adr);
          log_dat.push_back(bus.dat_w);
          log_sel.push_back(bus.sel);
        end else begin
          rd_cnt++;
          bus.dat_r = 32'(mem[bus.adr]) << (8 * bus.adr[1:0]);
        end
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cursor(input string tag, input int col, input int row);
    check({tag, "_col"}, 32'(cur_col_o), 32'(col));
    check({tag, "_row"}, 32'(cur_row_o), 32'(row));
  endtask

  task automatic offer(input logic [7:0] c, input logic [7:0] a);
    int guard;
    guard = 0;
    while (!ch_ready_o && guard < 40000) begin
      tick();
      guard++;
    end
    if (!ch_ready_o) check("ready_timeout", 32'(ch_ready_o), 32'd1);
    ch_dat_i   = c;
    attr_i     = a;
    ch_valid_i = 1'b1;
    tick();
    ch_valid_i = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy_o && cyc < 40000) begin
      tick();
      cyc++;
    end
    if (busy_o) check("busy_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a, output int cyc);
    offer(c, a);
    wait_idle(cyc);
  endtask

  int cyc, bad, bad_a, wr0, rd0;
  logic [7:0] c;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'hEE;
    bus.dat_r = '0;

    // Reset state
    rst_i = 1'b0;
    tick(); tick(); tick();
    check("rst_stb", 32'(bus.stb), 32'd0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_adr", 32'(bus.adr), 32'd0);
    check("rst_dat", bus.dat_w, 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_ready", 32'(ch_ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd1);
    check_cursor("rst", 0, 0);

    // Power-on clear
    rst_i = 1'b1;
    tick();
    check("clr_entry_stb", 32'(bus.stb), 32'd1);
    check("clr_entry_we", 32'(bus.we), 32'd1);
    wait_idle(cyc);
    check("clear_cycles", cyc, 32'd9600);
    check("clear_writes", wr_cnt, 32'd9600);
    check("clear_ready", 32'(ch_ready_o), 32'd1);
    check_cursor("clear", 0, 0);
    bad = 0; bad_a = 0;
    for (int i = 0; i < 4800; i++) begin
      if (mem[i] !== 8'h20) bad++;
      if (mem[8192 + i] !== 8'h07) bad_a++;
    end
    check("clear_char_bad", bad, 32'd0);
    check("clear_attr_bad", bad_a, 32'd0);

    // 'A' at (0,0)
    log_adr.delete(); log_dat.delete(); log_sel.delete();
    send(8'h41, 8'h12, cyc);
    check("A_cycles", cyc, 32'd2);
    check("A_nwr", log_adr.size(), 32'd2);
    check("A_c_adr", 32'(log_adr[0]), 32'h0000);
    check("A_c_dat", log_dat[0], 32'h41414141);
    check("A_c_sel", 32'(log_sel[0]), 32'b0001);
    check("A_a_adr", 32'(log_adr[1]), 32'h2000);
    check("A_a_dat", log_dat[1], 32'h12121212);
    check("A_a_sel", 32'(log_sel[1]), 32'b0001);
    check_cursor("A", 1, 0);

    // 'B' at (1,0): lane 1
    log_adr.delete(); log_dat.delete(); log_sel.delete();
    send(8'h42, 8'h07, cyc);
    check("B_c_adr", 32'(log_adr[0]), 32'h0001);
    check("B_c_sel", 32'(log_sel[0]), 32'b0010);
    check_cursor("B", 2, 0);

    // LF from row 0 stays off the bus
    send(8'h0A, 8'h07, cyc);
    check("LF_cycles", cyc, 32'd0);
    check_cursor("LF", 0, 1);

    // "HI" with three wait states per access
    waits = 3;
    send(8'h48, 8'h34, cyc);
    check("wait_cycles", cyc, 32'd8);
    send(8'h49, 8'h34, cyc);
    waits = 0;
    check("wait_H", 32'(mem[80]), 32'h48);
    check("wait_I", 32'(mem[81]), 32'h49);
    check("wait_H_attr", 32'(mem[8192 + 80]), 32'h34);
    check("wait_I_attr", 32'(mem[8192 + 81]), 32'h34);
    check_cursor("wait", 2, 1);

    // "hello" at row 3, then BS / CR / BS
    send(8'h0A, 8'h07, cyc);
    send(8'h0A, 8'h07, cyc);
    send(8'h68, 8'h07, cyc); send(8'h65, 8'h07, cyc); send(8'h6C, 8'h07, cyc);
    send(8'h6C, 8'h07, cyc); send(8'h6F, 8'h07, cyc);
    check_cursor("hello", 5, 3);
    wr0 = wr_cnt; rd0 = rd_cnt;
    send(8'h08, 8'h07, cyc);
    check_cursor("bs1", 4, 3);
    send(8'h0D, 8'h07, cyc);
    check_cursor("cr", 0, 3);
    send(8'h08, 8'h07, cyc);
    check_cursor("bs2", 0, 3);
    send(8'h01, 8'h07, cyc);
    check_cursor("ignored", 0, 3);
    check("ctl_no_bus", wr_cnt - wr0 + rd_cnt - rd0, 32'd0);

    // Walk to (79,59)
    for (int i = 0; i < 56; i++) send(8'h0A, 8'h07, cyc);
    check_cursor("row59", 0, 59);
    for (int i = 0; i < 79; i++) begin
      c = 8'h61 + 8'(i % 26);
      send(c, 8'h07, cyc);
    end
    check_cursor("col79", 79, 59);

    // 'Z' at the last cell triggers wrap and scroll
    log_adr.delete(); log_dat.delete(); log_sel.delete();
    wr0 = wr_cnt; rd0 = rd_cnt;
    send(8'h5A, 8'h5E, cyc);
    check("Z_cycles", cyc, 32'd28482);
    check("Z_c_adr", 32'(log_adr[0]), 32'd4799);
    check("Z_c_dat", log_dat[0], 32'h5A5A5A5A);
    check("Z_c_sel", 32'(log_sel[0]), 32'b1000);
    check("Z_a_adr", 32'(log_adr[1]), 32'h32BF);
    check("scroll_reads", rd_cnt - rd0, 32'd9440);
    check("scroll_writes", wr_cnt - wr0, 32'd9602);
    check_cursor("scroll", 0, 59);
    check("row0_H", 32'(mem[0]), 32'h48);
    check("row0_I", 32'(mem[1]), 32'h49);
    check("row0_attr", 32'(mem[8192]), 32'h34);
    check("row0_blank", 32'(mem[2]), 32'h20);
    check("row2_h", 32'(mem[160]), 32'h68);
    check("row58_a", 32'(mem[4640]), 32'h61);
    check("row58_Z", 32'(mem[4719]), 32'h5A);
    check("row58_Z_attr", 32'(mem[8192 + 4719]), 32'h5E);
    bad = 0; bad_a = 0;
    for (int i = 4720; i < 4800; i++) begin
      if (mem[i] !== 8'h20) bad++;
      if (mem[8192 + i] !== 8'h5E) bad_a++;
    end
    check("row59_char_bad", bad, 32'd0);
    check("row59_attr_bad", bad_a, 32'd0);

    // Reset in the middle of a scroll
    offer(8'h0A, 8'h07);
    repeat (1000) tick();
    check("midscroll_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    tick();
    check("rst_mid_stb", 32'(bus.stb), 32'd0);
    check("rst_mid_busy", 32'(busy_o), 32'd1);
    check_cursor("rst_mid", 0, 0);
    tick();
    rst_i = 1'b1;
    wr0 = wr_cnt;
    tick();
    check("reclr_stb", 32'(bus.stb), 32'd1);
    check("reclr_adr", 32'(bus.adr), 32'd0);
    wait_idle(cyc);
    check("reclr_cycles", cyc, 32'd9600);
    check("reclr_writes", wr_cnt - wr0, 32'd9600);
    check("reclr_attr", 32'(mem[8192 + 4719]), 32'h07);
    check("reclr_char", 32'(mem[0]), 32'h20);

    // Form feed clears with its own attribute and homes the cursor
    send(8'h78, 8'h07, cyc);
    check_cursor("pre_ff", 1, 0);
    send(8'h0C, 8'h1F, cyc);
    check("ff_cycles", cyc, 32'd9600);
    check_cursor("ff", 0, 0);
    check("ff_char", 32'(mem[0]), 32'h20);
    check("ff_attr", 32'(mem[8192 + 4799]), 32'h1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
